// File: rtl/proc_pkg.sv
// Shared opcode constants, FSM state encoding and decoded control vector for the
// proc_sequencer slice.
package proc_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_LI   = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StHalt   = 3'd4
    } state_t;

    // retire and halt are sequencer-internal; the rest leave the block as strobes
    typedef struct packed {
        logic reg_write;
        logic reg_dst;
        logic pc_src;
        logic data_write;
        logic pc_en;
        logic retire;
        logic halt;
    } ctrl_t;

endpackage

// File: rtl/proc_decode.sv
// Combinational opcode-to-control-vector decoder; all-zero when not enabled.
// PROC_SEQ_HALT_EN selects whether opcode 10 is a halt or a NOP.
module proc_decode
    import proc_pkg::*;
(
    input  logic       en,
    input  logic [1:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (en) begin
            unique case (opcode)
                OP_ADD: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.data_write = 1'b1;
                    ctrl.pc_en      = 1'b1;
                    ctrl.retire     = 1'b1;
                end
                OP_LI: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    ctrl.pc_en     = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                OP_JMP: begin
                    ctrl.pc_src = 1'b1;
                    ctrl.pc_en  = 1'b1;
                    ctrl.retire = 1'b1;
                end
                OP_HALT: begin
`ifdef PROC_SEQ_HALT_EN
                    ctrl.halt = 1'b1;
`else
                    ctrl.pc_en  = 1'b1;
                    ctrl.retire = 1'b1;
`endif
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle fetch/decode/execute control sequencer with registered strobes.
// Optional halt instruction enabled by defining PROC_SEQ_HALT_EN.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             fetch_req,
    input  logic             fetch_ack,
    input  logic [7:0]       ins_code,
    output logic [7:0]       ir,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             pc_src,
    output logic             data_write,
    output logic             pc_en,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retire_cnt
);

    state_t           state;
    logic [7:0]       ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             halt_q;
    logic             fetch_req_q;
    logic             busy_q;
    logic             reg_write_q;
    logic             reg_dst_q;
    logic             pc_src_q;
    logic             data_write_q;
    logic             pc_en_q;
    logic             exec_next;
    ctrl_t            dec_ctrl;

    // Decoder is enabled only on the cycle that enters EXEC, so the registered
    // strobes are high for exactly the EXEC cycle and derive from ir alone.
    assign exec_next = (state == StDecode);

    proc_decode u_decode (
        .en     (exec_next),
        .opcode (ir_q[7:6]),
        .ctrl   (dec_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            ir_q         <= '0;
            cnt_q        <= '0;
            halt_q       <= 1'b0;
            fetch_req_q  <= 1'b0;
            busy_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            pc_src_q     <= 1'b0;
            data_write_q <= 1'b0;
            pc_en_q      <= 1'b0;
        end else begin
            reg_write_q  <= dec_ctrl.reg_write;
            reg_dst_q    <= dec_ctrl.reg_dst;
            pc_src_q     <= dec_ctrl.pc_src;
            data_write_q <= dec_ctrl.data_write;
            pc_en_q      <= dec_ctrl.pc_en;
            unique case (state)
                StIdle: begin
                    if (run) begin
                        state       <= StFetch;
                        fetch_req_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StFetch: begin
                    if (fetch_ack) begin
                        ir_q        <= ins_code;
                        state       <= StDecode;
                        fetch_req_q <= 1'b0;
                    end
                end
                StDecode: begin
                    state  <= StExec;
                    halt_q <= dec_ctrl.halt;
                    // counting on EXEC entry makes the new total visible during EXEC
                    if (dec_ctrl.retire) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StExec: begin
                    if (halt_q) begin
                        state  <= StHalt;
                        busy_q <= 1'b0;
                    end else if (run) begin
                        state       <= StFetch;
                        fetch_req_q <= 1'b1;
                    end else begin
                        state  <= StIdle;
                        busy_q <= 1'b0;
                    end
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    state       <= StIdle;
                    fetch_req_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_req  = fetch_req_q;
    assign busy       = busy_q;
    assign ir         = ir_q;
    assign retire_cnt = cnt_q;
    assign reg_write  = reg_write_q;
    assign reg_dst    = reg_dst_q;
    assign pc_src     = pc_src_q;
    assign data_write = data_write_q;
    assign pc_en      = pc_en_q;

`ifdef PROC_SEQ_HALT_EN
    assign halted = (state == StHalt);
`else
    assign halted = 1'b0;
`endif

endmodule
